// File: rtl/kaipokrandt_mcu_pkg.sv
// Shared constants for the microcontroller core.
// Holds the instruction opcodes, the ALU operation codes consumed by the
// execution FSMs, the decoded instruction classes and the dispatch
// sequencer state encoding.
package kaipokrandt_mcu_pkg;

    // Opcodes, instruction bits [15:12]
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_SUBI = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    // ALU operation codes shared with the execution FSMs
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    // Decoded instruction class
    localparam logic [1:0] CLS_NOP  = 2'd0;
    localparam logic [1:0] CLS_ALU  = 2'd1;
    localparam logic [1:0] CLS_HALT = 2'd2;
    localparam logic [1:0] CLS_ILL  = 2'd3;

    // Dispatch sequencer states
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_FETCH     = 4'd1;
    localparam logic [3:0] ST_WAIT_MEM  = 4'd2;
    localparam logic [3:0] ST_DECODE    = 4'd3;
    localparam logic [3:0] ST_DISPATCH  = 4'd4;
    localparam logic [3:0] ST_WAIT_DONE = 4'd5;
    localparam logic [3:0] ST_ADVANCE   = 4'd6;
    localparam logic [3:0] ST_HALT      = 4'd7;
    localparam logic [3:0] ST_ERROR     = 4'd8;

endpackage

// File: rtl/kaipokrandt_instr_decode.sv
// Combinational instruction decoder.
// Ports:
//   ir      in  16  instruction word
//   cls     out 2   instruction class (CLS_NOP / CLS_ALU / CLS_HALT / CLS_ILL)
//   is_imm  out 1   ALU op takes the immediate operand
//   alu_op  out 4   ALU operation code (0 unless class is ALU)
//   dst     out 4   destination register field [11:8]
//   src     out 4   source register field [7:4]
//   imm     out 8   immediate field [7:0] (overlaps src)
//   illegal out 1   opcode is not defined
module kaipokrandt_instr_decode
    import kaipokrandt_mcu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [1:0]  cls,
    output logic        is_imm,
    output logic [3:0]  alu_op,
    output logic [3:0]  dst,
    output logic [3:0]  src,
    output logic [7:0]  imm,
    output logic        illegal
);

    assign dst = ir[11:8];
    assign src = ir[7:4];
    assign imm = ir[7:0];

    always_comb begin
        cls     = CLS_ILL;
        is_imm  = 1'b0;
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (ir[15:12])
            OP_NOP:  cls = CLS_NOP;
            OP_HALT: cls = CLS_HALT;
            OP_ADD: begin
                cls    = CLS_ALU;
                alu_op = ALU_ADD;
            end
            OP_SUB: begin
                cls    = CLS_ALU;
                alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                cls    = CLS_ALU;
                is_imm = 1'b1;
                alu_op = ALU_ADD;
            end
            OP_SUBI: begin
                cls    = CLS_ALU;
                is_imm = 1'b1;
                alu_op = ALU_SUB;
            end
            default: begin
                cls     = CLS_ILL;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/kaipokrandt_instr_dispatch.sv
// Instruction fetch/dispatch sequencer.
// Fetches 16-bit instructions from synchronous program memory, decodes them,
// issues a one-cycle start to the execution FSMs, waits for their done
// handshake under a watchdog, then advances the PC.
// Ports:
//   clk, reset (async, active-high)
//   run                 level enable, leaves IDLE when high
//   mem_rd, mem_addr    program memory read strobe / address (= pc)
//   mem_rdata           instruction word, valid the cycle after mem_rd
//   start               one-cycle command pulse to execution FSMs
//   dec_alu_rr, dec_alu_imm, uses_imm, alu_op, dst_sel, src_sel, imm_val
//                       decoded command fields, held through DISPATCH/WAIT_DONE
//   exec_busy, exec_done OR of execution FSM busy / done flags
//   halted, err         sticky status until reset
module kaipokrandt_instr_dispatch
    import kaipokrandt_mcu_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 16
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            mem_rd,
    output logic [PC_W-1:0] mem_addr,
    input  logic [15:0]     mem_rdata,
    output logic            start,
    output logic            dec_alu_rr,
    output logic            dec_alu_imm,
    output logic            uses_imm,
    output logic [3:0]      alu_op,
    output logic [3:0]      dst_sel,
    output logic [3:0]      src_sel,
    output logic [7:0]      imm_val,
    input  logic            exec_busy,
    input  logic            exec_done,
    output logic            halted,
    output logic            err
);

    // Counter only needs to reach TIMEOUT-1
    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [3:0]       state_reg, state_next;
    logic [PC_W-1:0]  pc_reg;
    logic [15:0]      ir_reg;
    logic [CNT_W-1:0] wd_cnt_reg;

    logic             dec_alu_rr_reg, dec_alu_imm_reg;
    logic [3:0]       alu_op_reg, dst_sel_reg, src_sel_reg;
    logic [7:0]       imm_val_reg;

    logic [1:0]       d_cls;
    logic             d_is_imm, d_illegal;
    logic [3:0]       d_alu_op, d_dst, d_src;
    logic [7:0]       d_imm;

    kaipokrandt_instr_decode u_decode (
        .ir      (ir_reg),
        .cls     (d_cls),
        .is_imm  (d_is_imm),
        .alu_op  (d_alu_op),
        .dst     (d_dst),
        .src     (d_src),
        .imm     (d_imm),
        .illegal (d_illegal)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (run) state_next = ST_FETCH;
            ST_FETCH:    state_next = ST_WAIT_MEM;
            ST_WAIT_MEM: state_next = ST_DECODE;
            ST_DECODE: begin
                if (d_illegal) begin
                    state_next = ST_ERROR;
                end else begin
                    case (d_cls)
                        CLS_NOP:  state_next = ST_ADVANCE;
                        CLS_HALT: state_next = ST_HALT;
                        CLS_ALU:  state_next = ST_DISPATCH;
                        default:  state_next = ST_ERROR;
                    endcase
                end
            end
            ST_DISPATCH: if (!exec_busy) state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (exec_done)                     state_next = ST_ADVANCE;
                else if (wd_cnt_reg == CNT_LAST)   state_next = ST_ERROR;
            end
            ST_ADVANCE:  state_next = run ? ST_FETCH : ST_IDLE;
            ST_HALT:     state_next = ST_HALT;
            ST_ERROR:    state_next = ST_ERROR;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            pc_reg     <= '0;
            ir_reg     <= '0;
            wd_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_WAIT_MEM)
                ir_reg <= mem_rdata;
            if (state_reg == ST_ADVANCE)
                pc_reg <= pc_reg + 1'b1;   // wraps modulo 2^PC_W
            // DISPATCH always precedes WAIT_DONE, so clearing there gives
            // index 0 on the first WAIT_DONE cycle.
            if (state_reg == ST_DISPATCH)
                wd_cnt_reg <= '0;
            else if (state_reg == ST_WAIT_DONE && !exec_done && wd_cnt_reg != CNT_LAST)
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
        end
    end

    // Command fields: loaded only for ALU ops leaving DECODE, cleared on
    // entry to ADVANCE/HALT/ERROR, otherwise held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dec_alu_rr_reg  <= 1'b0;
            dec_alu_imm_reg <= 1'b0;
            alu_op_reg      <= '0;
            dst_sel_reg     <= '0;
            src_sel_reg     <= '0;
            imm_val_reg     <= '0;
        end else if (state_reg == ST_DECODE && state_next == ST_DISPATCH) begin
            dec_alu_rr_reg  <= ~d_is_imm;
            dec_alu_imm_reg <= d_is_imm;
            alu_op_reg      <= d_alu_op;
            dst_sel_reg     <= d_dst;
            src_sel_reg     <= d_src;
            imm_val_reg     <= d_imm;
        end else if (state_next == ST_ADVANCE || state_next == ST_HALT
                     || state_next == ST_ERROR) begin
            dec_alu_rr_reg  <= 1'b0;
            dec_alu_imm_reg <= 1'b0;
            alu_op_reg      <= '0;
            dst_sel_reg     <= '0;
            src_sel_reg     <= '0;
            imm_val_reg     <= '0;
        end
    end

    // start is decoded from state so it drops the instant reset asserts;
    // DISPATCH exits right after the issuing cycle, so it cannot repeat.
    assign start       = (state_reg == ST_DISPATCH) && !exec_busy;
    assign mem_rd      = (state_reg == ST_FETCH);
    assign mem_addr    = pc_reg;
    assign halted      = (state_reg == ST_HALT);
    assign err         = (state_reg == ST_ERROR);
    assign dec_alu_rr  = dec_alu_rr_reg;
    assign dec_alu_imm = dec_alu_imm_reg;
    assign uses_imm    = dec_alu_imm_reg;
    assign alu_op      = alu_op_reg;
    assign dst_sel     = dst_sel_reg;
    assign src_sel     = src_sel_reg;
    assign imm_val     = imm_val_reg;

endmodule

// File: tb/tb_kaipokrandt_instr_dispatch.sv
module tb_kaipokrandt_instr_dispatch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = 16'h0;
    logic        start, dec_alu_rr, dec_alu_imm, uses_imm;
    logic [3:0]  alu_op, dst_sel, src_sel;
    logic [7:0]  imm_val;
    logic        exec_busy, exec_done, halted, err;

    int n_checks = 0;
    int n_errors = 0;

    kaipokrandt_instr_dispatch #(.PC_W(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .start(start), .dec_alu_rr(dec_alu_rr), .dec_alu_imm(dec_alu_imm),
        .uses_imm(uses_imm), .alu_op(alu_op), .dst_sel(dst_sel),
        .src_sel(src_sel), .imm_val(imm_val),
        .exec_busy(exec_busy), .exec_done(exec_done),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    // Program memory: synchronous read
    logic [15:0] mem [256];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    // Execution model: busy for busy_req cycles once a command is presented,
    // done pulse done_delay cycles after start (0 = never).
    int  busy_req = 0;
    int  done_delay = 0;
    int  busy_used;
    int  done_cnt;
    wire dec_active = dec_alu_rr | dec_alu_imm;
    assign exec_busy = dec_active && (busy_used < busy_req);
    assign exec_done = (done_delay != 0) && (done_cnt == done_delay);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_used <= 0;
            done_cnt  <= 0;
        end else begin
            if (!dec_active)    busy_used <= 0;
            else if (exec_busy) busy_used <= busy_used + 1;
            if (start)            done_cnt <= 1;
            else if (!dec_active) done_cnt <= 0;
            else if (done_cnt != 0) done_cnt <= done_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {mem_rd, mem_addr, start, dec_alu_rr, dec_alu_imm, uses_imm,
                alu_op, dst_sel, src_sel, imm_val, halted, err};
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    typedef struct {
        string       name;
        logic [15:0] instr;
        int busy, delay;
        int exp_end, exp_halted, exp_err, exp_pc, exp_starts, exp_start_cyc;
        int exp_rr, exp_imm, exp_op, exp_dst, exp_src, exp_immv, exp_fetch;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int c, end_c, starts, start_c, fetch, have_cap, stable_bad, dbl, prev_start, post_bad;
        int wrap_c, seen255, fetch_c2, ok;
        logic [23:0] cap;

        // Cycle 1 = FETCH after reset release with run high.
        //           name           instr    b  d   end h e pc st sc rr im op dst src imm f
        vecs[0] = '{"addi",        16'h3205, 0, 5, 14, 1, 0, 1, 1, 4, 0, 1, 0, 2, 0, 'h05, 2};
        vecs[1] = '{"add_busy3",   16'h1AB7, 3, 5, 17, 1, 0, 1, 1, 7, 1, 0, 0, 'hA, 'hB, 'hB7, 2};
        vecs[2] = '{"sub_timeout", 16'h2345, 0, 0, 21, 0, 1, 0, 1, 4, 1, 0, 1, 3, 4, 'h45, 1};
        vecs[3] = '{"subi_last",   16'h4C9E, 1, 16, 26, 1, 0, 1, 1, 5, 0, 1, 1, 'hC, 9, 'h9E, 2};
        vecs[4] = '{"subi_late",   16'h4C9E, 0, 17, 21, 0, 1, 0, 1, 4, 0, 1, 1, 'hC, 9, 'h9E, 1};
        vecs[5] = '{"add_fast",    16'h1010, 0, 1, 10, 1, 0, 1, 1, 4, 1, 0, 0, 0, 1, 'h10, 2};
        vecs[6] = '{"nop",         16'h0000, 0, 5, 8, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2};
        vecs[7] = '{"illegal7",    16'h7123, 0, 5, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[8] = '{"illegalE",    16'hE0FF, 0, 5, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[9] = '{"halt",        16'hF000, 0, 5, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

        clear_mem();
        tick(); tick();
        check("reset_outputs", all_outs(), 64'h0);
        reset = 1'b0;

        // ---------------- table-driven single-instruction programs
        for (int v = 0; v < 10; v++) begin
            clear_mem();
            mem[0] = vecs[v].instr;
            mem[1] = 16'hF000;
            busy_req = vecs[v].busy;
            done_delay = vecs[v].delay;
            run = 1'b1;
            do_reset();
            c = 0; end_c = 0; starts = 0; start_c = 0; fetch = 0;
            have_cap = 0; stable_bad = 0; dbl = 0; prev_start = 0; cap = '0;
            while (end_c == 0 && c < 100) begin
                tick();
                c++;
                if (mem_rd) fetch++;
                if (start) begin
                    if (prev_start != 0) dbl = 1;
                    starts++;
                    start_c = c;
                end
                prev_start = int'(start);
                if (dec_active) begin
                    if (have_cap == 0) begin
                        cap = {dec_alu_rr, dec_alu_imm, uses_imm, 1'b0, alu_op, dst_sel, src_sel, imm_val};
                        have_cap = 1;
                    end else if (cap != {dec_alu_rr, dec_alu_imm, uses_imm, 1'b0, alu_op, dst_sel, src_sel, imm_val}) begin
                        stable_bad = 1;
                    end
                end
                if (halted || err) end_c = c;
            end
            $display("vec %s: instr=%04h end=%0d starts=%0d start_cyc=%0d pc=%0d halted=%0b err=%0b",
                     vecs[v].name, vecs[v].instr, end_c, starts, start_c, mem_addr, halted, err);
            check({vecs[v].name, ".end_cycle"}, end_c, vecs[v].exp_end);
            check({vecs[v].name, ".halted"}, halted, vecs[v].exp_halted);
            check({vecs[v].name, ".err"}, err, vecs[v].exp_err);
            check({vecs[v].name, ".pc"}, mem_addr, vecs[v].exp_pc);
            check({vecs[v].name, ".starts"}, starts, vecs[v].exp_starts);
            check({vecs[v].name, ".start_cycle"}, start_c, vecs[v].exp_start_cyc);
            check({vecs[v].name, ".fetches"}, fetch, vecs[v].exp_fetch);
            check({vecs[v].name, ".dec_alu_rr"}, cap[23], vecs[v].exp_rr);
            check({vecs[v].name, ".dec_alu_imm"}, cap[22], vecs[v].exp_imm);
            check({vecs[v].name, ".uses_imm"}, cap[21], vecs[v].exp_imm);
            check({vecs[v].name, ".alu_op"}, cap[19:16], vecs[v].exp_op);
            check({vecs[v].name, ".dst_sel"}, cap[15:12], vecs[v].exp_dst);
            check({vecs[v].name, ".src_sel"}, cap[11:8], vecs[v].exp_src);
            check({vecs[v].name, ".imm_val"}, cap[7:0], vecs[v].exp_immv);
            check({vecs[v].name, ".fields_stable"}, stable_bad, 0);
            check({vecs[v].name, ".no_double_start"}, dbl, 0);
            // Terminal state is sticky: no fetch, no start, fields cleared
            post_bad = 0;
            for (int k = 0; k < 5; k++) begin
                if (mem_rd || start || dec_active || alu_op != 0 || dst_sel != 0
                    || src_sel != 0 || imm_val != 0 || halted != 1'(vecs[v].exp_halted)
                    || err != 1'(vecs[v].exp_err))
                    post_bad = 1;
                tick();
            end
            check({vecs[v].name, ".sticky"}, post_bad, 0);
        end

        // ---------------- NOP x3 then HALT: 4 cycles per NOP
        clear_mem();
        mem[3] = 16'hF000;
        busy_req = 0; done_delay = 5; run = 1'b1;
        do_reset();
        c = 0; end_c = 0; starts = 0; fetch = 0; fetch_c2 = 0;
        while (end_c == 0 && c < 60) begin
            tick(); c++;
            if (mem_rd) begin
                fetch++;
                if (fetch == 2) fetch_c2 = c;
            end
            if (start) starts++;
            if (halted || err) end_c = c;
        end
        $display("seq nop3_halt: end=%0d fetches=%0d pc=%0d", end_c, fetch, mem_addr);
        check("nop3.end_cycle", end_c, 16);
        check("nop3.second_fetch", fetch_c2, 5);
        check("nop3.starts", starts, 0);
        check("nop3.pc", mem_addr, 3);
        check("nop3.halted", halted, 1);

        // ---------------- 256 NOPs: pc wraps 255 -> 0
        clear_mem();
        do_reset();
        c = 0; wrap_c = 0; seen255 = 0; ok = 0;
        while (ok == 0 && c < 1100) begin
            tick(); c++;
            if (mem_rd && mem_addr == 8'd255) seen255 = 1;
            else if (mem_rd && mem_addr == 8'd0 && seen255 != 0 && wrap_c == 0) wrap_c = c;
            else if (mem_rd && mem_addr == 8'd1 && wrap_c != 0) ok = 1;
        end
        $display("seq pc_wrap: wrap_fetch_cycle=%0d continued=%0d", wrap_c, ok);
        check("wrap.fetch0_cycle", wrap_c, 1025);
        check("wrap.continues", ok, 1);
        check("wrap.no_err", err, 0);

        // ---------------- run dropped mid-instruction
        clear_mem();
        mem[0] = 16'h3205; mem[1] = 16'hF000;
        done_delay = 5; run = 1'b1;
        do_reset();
        c = 0; fetch = 0;
        while (c < 20) begin
            tick(); c++;
            if (mem_rd) fetch++;
            if (start) run = 1'b0;
        end
        $display("seq run_drop: fetches=%0d pc=%0d halted=%0b", fetch, mem_addr, halted);
        check("rundrop.fetches", fetch, 1);
        check("rundrop.pc", mem_addr, 1);
        check("rundrop.idle_not_halted", halted, 0);
        run = 1'b1;
        c = 0;
        while (!halted && c < 20) begin tick(); c++; end
        check("rundrop.resume_halted", halted, 1);
        check("rundrop.resume_pc", mem_addr, 1);

        // ---------------- reset during DISPATCH drops start immediately
        clear_mem();
        mem[0] = 16'h1010;
        done_delay = 0; run = 1'b1;
        do_reset();
        c = 0;
        while (!start && c < 10) begin tick(); c++; end
        check("rst_dispatch.start_before", start, 1);
        #2 reset = 1'b1;
        #1;
        $display("seq reset_in_dispatch: start=%0b outs=%0h", start, all_outs());
        check("rst_dispatch.start_after", start, 0);
        check("rst_dispatch.outs", all_outs(), 64'h0);
        @(posedge clk); #1 reset = 1'b0;

        // ---------------- reset during WAIT_DONE, then restart at address 0
        c = 0;
        while (!start && c < 10) begin tick(); c++; end
        tick(); tick(); tick();
        check("rst_wait.busy_before", dec_alu_rr, 1);
        #3 reset = 1'b1;
        #1;
        check("rst_wait.outs", all_outs(), 64'h0);
        @(posedge clk); #1 reset = 1'b0;
        c = 0;
        while (!mem_rd && c < 10) begin tick(); c++; end
        $display("seq reset_in_wait_done: refetch_cycle=%0d addr=%0d", c, mem_addr);
        check("rst_wait.refetch_cycle", c, 1);
        check("rst_wait.refetch_addr", mem_addr, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
